cdc_req_sender: RTL



---
 rtl/cdc_req_sender.sv | 123 ++++++++++++
 1 files changed

// File: rtl/cdc_req_sender.sv
// Source-side half of a 4-phase req/ack crossing: turns event pulses into req levels,
// queues events while a handshake is in flight and flags overflow/timeout stalls.
module cdc_req_sender #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 3,
  parameter int TIMEOUT     = 1023
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             event_pulse,
  input  logic             ack_async,
  input  logic             clear_err,
  output logic             req,
  output logic             busy,
  output logic             done_pulse,
  output logic [CNT_W-1:0] pending_count,
  output logic             overflow,
  output logic             timeout_err
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ_HIGH, REQ_LOW} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                   ack_s;
  logic                   req_q, req_d;
  logic                   done_q, done_d;
  logic [CNT_W-1:0]       pend_q, pend_d;
  logic                   ovf_q, ovf_d;
  logic                   tmo_err_q, tmo_err_d;
  logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic                   launch, pend_nz, inc, dec, drop, tmo_hit;

  // Only the synchronized copy of ack is ever looked at.
  assign ack_s   = ack_sync_q[SYNC_STAGES-1];
  assign pend_nz = (pend_q != '0);

  // State register and all other flops
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ack_sync_q <= '0;
      req_q      <= 1'b0;
      done_q     <= 1'b0;
      pend_q     <= '0;
      ovf_q      <= 1'b0;
      tmo_err_q  <= 1'b0;
      tmo_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_async};
      req_q      <= req_d;
      done_q     <= done_d;
      pend_q     <= pend_d;
      ovf_q      <= ovf_d;
      tmo_err_q  <= tmo_err_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    case (state_q)
      IDLE: begin
        if ((event_pulse || pend_nz) && !ack_s) begin
          launch  = 1'b1;
          state_d = REQ_HIGH;
        end
      end
      REQ_HIGH: if (ack_s)  state_d = REQ_LOW;
      REQ_LOW:  if (!ack_s) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Output logic: req and done are registered versions of the upcoming state
  always_comb begin
    busy   = (state_q != IDLE);
    req_d  = (state_d == REQ_HIGH);
    done_d = (state_q == REQ_LOW) && (state_d == IDLE);
  end

  // Pending queue, sticky errors and wait-state timer
  always_comb begin
    dec    = launch && pend_nz;
    inc    = event_pulse && !(launch && !pend_nz);
    drop   = 1'b0;
    pend_d = pend_q;
    if (inc && !dec) begin
      if (pend_q == CNT_MAX) drop = 1'b1;
      else                   pend_d = pend_q + 1'b1;
    end else if (dec && !inc) begin
      pend_d = pend_q - 1'b1;
    end

    tmo_cnt_d = tmo_cnt_q;
    tmo_hit   = 1'b0;
    if (state_q == IDLE || state_d != state_q) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q != TMO_MAX) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
      // Fire once on the step that reaches the limit, so clear_err can stick afterwards.
      tmo_hit   = (tmo_cnt_q == TMO_LAST);
    end

    ovf_d     = drop    || (ovf_q     && !clear_err);
    tmo_err_d = tmo_hit || (tmo_err_q && !clear_err);
  end

  assign req           = req_q;
  assign done_pulse    = done_q;
  assign pending_count = pend_q;
  assign overflow      = ovf_q;
  assign timeout_err   = tmo_err_q;

endmodule
